// File: rtl/dense_layer_engine.sv
// ============================================================================
//  Module      : dense_layer_engine
//  Description : Fully-connected layer datapath. NEURONS signed MAC lanes
//                accumulate IN_LEN activation beats, then add bias, apply
//                ReLU and requantise into out_vec with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dense_layer_engine #(
    parameter int IN_LEN  = 784,
    parameter int NEURONS = 128,
    parameter int DW      = 8,
    parameter int WW      = 8,
    parameter int ACCW    = 32,
    parameter int SHIFT   = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    act_valid,
    input  logic [DW-1:0]           act_in,
    input  logic [NEURONS*WW-1:0]   w_in,
    input  logic [NEURONS*WW-1:0]   b_in,
    output logic                    busy,
    output logic                    done,
    output logic [NEURONS*DW-1:0]   out_vec
);

    localparam int              c_CNTW    = $clog2(IN_LEN + 1);
    localparam int              c_PW      = DW + WW + 1;
    localparam logic [c_CNTW-1:0] c_LAST_M1 = c_CNTW'(IN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_BIAS  = 3'd2,
        S_OUT   = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNTW-1:0]       r_count;
    logic                    r_done;
    logic [NEURONS*DW-1:0]   r_out;
    logic [NEURONS*DW-1:0]   w_quant;
    logic                    w_start;
    logic                    w_accept;
    logic                    w_add_bias;

    assign w_start    = (r_state == S_IDLE) && run;
    assign w_accept   = (r_state == S_ACCUM) && run && act_valid;
    assign w_add_bias = (r_state == S_BIAS) && run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping run aborts from ACCUM/BIAS; once OUT is reached the result is committed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (run) w_state_nxt = S_ACCUM;
            S_ACCUM: begin
                if (!run)
                    w_state_nxt = S_IDLE;
                else if (act_valid && (r_count == c_LAST_M1))
                    w_state_nxt = S_BIAS;
            end
            S_BIAS:  w_state_nxt = run ? S_OUT : S_IDLE;
            S_OUT:   w_state_nxt = S_WAIT;
            S_WAIT:  if (!run) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NEURONS; k++) begin : g_lane
            logic signed [ACCW-1:0] r_acc;
            logic signed [c_PW-1:0] w_prod;
            logic signed [ACCW-1:0] w_prod_ext;
            logic signed [ACCW-1:0] w_bias_ext;
            logic signed [ACCW-1:0] w_shifted;

            assign w_prod     = $signed({1'b0, act_in}) * $signed(w_in[k*WW +: WW]);
            assign w_prod_ext = {{(ACCW-c_PW){w_prod[c_PW-1]}}, w_prod};
            assign w_bias_ext = {{(ACCW-WW){b_in[k*WW+WW-1]}}, b_in[k*WW +: WW]};
            assign w_shifted  = r_acc >>> SHIFT;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_acc <= '0;
                end else if (w_start) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    r_acc <= r_acc + w_prod_ext;
                end else if (w_add_bias) begin
                    r_acc <= r_acc + w_bias_ext;
                end
            end

            // ReLU first, so saturation is only ever needed on the high side.
            always_comb begin
                w_quant[k*DW +: DW] = w_shifted[DW-1:0];
                if (r_acc[ACCW-1])
                    w_quant[k*DW +: DW] = '0;
                else if (|w_shifted[ACCW-1:DW])
                    w_quant[k*DW +: DW] = '1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_OUT);
            if (r_state == S_OUT)
                r_out <= w_quant;
        end
    end

    assign busy    = (r_state == S_ACCUM) || (r_state == S_BIAS) || (r_state == S_OUT);
    assign done    = r_done;
    assign out_vec = r_out;

endmodule

`default_nettype wire

// File: tb/tb_dense_layer_engine.sv
// ============================================================================
//  Module      : tb_dense_layer_engine
//  Description : Self-checking bench for dense_layer_engine, small (4->2) and
//                full (784->128) configurations against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dense_layer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         s_run, s_valid, s_busy, s_done;
    logic [7:0]   s_act;
    logic [15:0]  s_w, s_b, s_out;

    logic         f_run, f_valid, f_busy, f_done;
    logic [7:0]   f_act;
    logic [1023:0] f_w, f_b, f_out;

    int n_checks = 0;
    int n_fail   = 0;
    int s_busy_cnt = 0;
    int s_done_cnt = 0;
    int f_done_cnt = 0;

    dense_layer_engine #(.IN_LEN(4), .NEURONS(2), .DW(8), .WW(8), .ACCW(32), .SHIFT(0)) u_small (
        .clk(clk), .rst(rst), .run(s_run), .act_valid(s_valid), .act_in(s_act),
        .w_in(s_w), .b_in(s_b), .busy(s_busy), .done(s_done), .out_vec(s_out)
    );

    dense_layer_engine #(.IN_LEN(784), .NEURONS(128), .DW(8), .WW(8), .ACCW(32), .SHIFT(7)) u_full (
        .clk(clk), .rst(rst), .run(f_run), .act_valid(f_valid), .act_in(f_act),
        .w_in(f_w), .b_in(f_b), .busy(f_busy), .done(f_done), .out_vec(f_out)
    );

    always @(negedge clk) begin
        if (s_busy === 1'b1) s_busy_cnt++;
        if (s_done === 1'b1) s_done_cnt++;
        if (f_done === 1'b1) f_done_cnt++;
    end

    // Reference: ReLU, arithmetic shift, saturate to 8-bit unsigned.
    function automatic int requant(input longint a, input int sh);
        longint v;
        if (a < 0) return 0;
        v = a >>> sh;
        if (v > 255) return 255;
        return int'(v);
    endfunction

    function automatic int small_ref(input int acts[4], input int w, input int b);
        longint acc = 0;
        for (int i = 0; i < 4; i++) acc += longint'(acts[i]) * longint'(w);
        return requant(acc + longint'(b), 0);
    endfunction

    // Drives one 4-beat layer on the small instance; run is left high.
    task automatic small_layer(input int acts[4], input int w0, input int w1, input int b0,
                               input int b1, input bit stall, output int lat, output int total,
                               output bit got);
        @(negedge clk);
        s_run = 1'b1; s_valid = 1'b0;
        s_w = {w1[7:0], w0[7:0]};
        s_b = {b1[7:0], b0[7:0]};
        @(posedge clk);
        total = 0; lat = 0; got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); s_valid = 1'b1; s_act = acts[i][7:0];
            @(posedge clk); total++;
            if (stall && i < 3) begin
                @(negedge clk); s_valid = 1'b0;
                @(posedge clk); total++;
            end
        end
        @(negedge clk); s_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (s_done === 1'b1) begin lat = c; got = 1'b1; break; end
        end
        total += lat;
    endtask

    task automatic small_end();
        @(negedge clk); s_run = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_run = 0; s_valid = 0; s_act = 0; s_w = 0; s_b = 0;
        f_run = 0; f_valid = 0; f_act = 0; f_w = '0; f_b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", s_done); end
        n_checks++; if (s_out !== 16'h0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", s_out); end
        n_checks++; if (f_out !== '0 || f_busy !== 1'b0) begin n_fail++; $display("FAIL reset_full busy=%b out_nonzero=%b", f_busy, |f_out); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", s_busy); end
    endtask

    task automatic test_basic();
        int acts[4] = '{1, 2, 3, 4};
        int lat, total; bit got;
        small_layer(acts, 1, -1, 0, 0, 1'b0, lat, total, got);
        n_checks++; if (!got || lat != 2) begin n_fail++; $display("FAIL basic_latency got=%0d seen=%b exp=2", lat, got); end
        n_checks++; if (s_out[7:0] !== 8'(small_ref(acts, 1, 0))) begin n_fail++; $display("FAIL basic_out0 got=%0d exp=%0d", s_out[7:0], small_ref(acts, 1, 0)); end
        n_checks++; if (s_out[15:8] !== 8'(small_ref(acts, -1, 0))) begin n_fail++; $display("FAIL basic_out1 got=%0d exp=%0d", s_out[15:8], small_ref(acts, -1, 0)); end
        n_checks++; if (s_out !== 16'h000A) begin n_fail++; $display("FAIL basic_const got=%h exp=000a", s_out); end
        small_end();
    endtask

    task automatic test_saturate();
        int acts[4] = '{255, 255, 255, 255};
        int lat, total, b0; bit got;
        b0 = s_busy_cnt;
        small_layer(acts, 127, 127, 127, 127, 1'b0, lat, total, got);
        n_checks++; if (s_out !== 16'hFFFF) begin n_fail++; $display("FAIL sat_out got=%h exp=ffff", s_out); end
        small_end();
        n_checks++; if (s_busy_cnt - b0 != 6) begin n_fail++; $display("FAIL sat_busy_cycles got=%0d exp=6", s_busy_cnt - b0); end
    endtask

    task automatic test_stall();
        int acts[4] = '{1, 2, 3, 4};
        int lat, total; bit got;
        small_layer(acts, 1, -1, 0, 0, 1'b1, lat, total, got);
        n_checks++; if (!got || total != 9) begin n_fail++; $display("FAIL stall_total got=%0d exp=9", total); end
        n_checks++; if (s_out !== 16'h000A) begin n_fail++; $display("FAIL stall_out got=%h exp=000a", s_out); end
        small_end();
    endtask

    task automatic test_abort();
        int acts[4] = '{1, 2, 3, 4};
        int lat, total, d0; bit got;
        logic [15:0] prev;
        prev = s_out; d0 = s_done_cnt;
        @(negedge clk); s_run = 1'b1; s_w = {8'hFF, 8'h01}; s_b = 16'h0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); s_valid = 1'b1; s_act = acts[i][7:0];
            @(posedge clk);
        end
        @(negedge clk); s_run = 1'b0; s_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (s_done_cnt != d0) begin n_fail++; $display("FAIL abort_done got=%0d exp=0", s_done_cnt - d0); end
        n_checks++; if (s_out !== prev) begin n_fail++; $display("FAIL abort_out got=%h exp=%h", s_out, prev); end
        n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", s_busy); end
        small_layer(acts, 1, -1, 0, 0, 1'b0, lat, total, got);
        n_checks++; if (!got || s_out !== 16'h000A) begin n_fail++; $display("FAIL abort_rerun got=%h exp=000a", s_out); end
        small_end();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); s_run = 1'b1; s_w = 16'h0101;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); s_valid = 1'b1; s_act = 8'(i + 1);
            @(posedge clk);
        end
        @(negedge clk); s_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", s_busy); end
        n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", s_done); end
        n_checks++; if (s_out !== 16'h0) begin n_fail++; $display("FAIL midrst_out got=%h exp=0", s_out); end
        @(negedge clk); s_run = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random_small();
        int acts[4];
        int w0, w1, b0, b1, lat, total; bit got;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 4; i++) acts[i] = int'($urandom_range(0, 15));
            w0 = int'($urandom_range(0, 15)) - 8;
            w1 = int'($urandom_range(0, 15)) - 8;
            b0 = int'($urandom_range(0, 40)) - 20;
            b1 = int'($urandom_range(0, 40)) - 20;
            small_layer(acts, w0, w1, b0, b1, it[0], lat, total, got);
            n_checks++;
            if (!got || s_out[7:0] !== 8'(small_ref(acts, w0, b0)) || s_out[15:8] !== 8'(small_ref(acts, w1, b1))) begin
                n_fail++;
                $display("FAIL rand_small it=%0d got=%h exp=%02h%02h", it, s_out,
                         8'(small_ref(acts, w1, b1)), 8'(small_ref(acts, w0, b0)));
            end
            small_end();
        end
    endtask

    task automatic test_full(input int amax, input int wm);
        longint mdl[128];
        int bv[128];
        int beats, lat, d0, act, wv; bit got;
        d0 = f_done_cnt;
        for (int k = 0; k < 128; k++) begin
            mdl[k] = 0;
            bv[k] = int'($urandom_range(0, 255)) - 128;
        end
        @(negedge clk); f_run = 1'b1; f_valid = 1'b0;
        for (int k = 0; k < 128; k++) f_b[k*8 +: 8] = bv[k][7:0];
        @(posedge clk);
        beats = 0;
        for (int c = 0; c < 4000 && beats < 784; c++) begin
            @(negedge clk);
            f_valid = ($urandom_range(0, 3) != 0);
            act = int'($urandom_range(0, amax));
            f_act = act[7:0];
            for (int k = 0; k < 128; k++) begin
                wv = int'($urandom_range(0, 2*wm - 1)) - wm;
                f_w[k*8 +: 8] = wv[7:0];
                if (f_valid) mdl[k] += longint'(act) * longint'(wv);
            end
            if (f_valid) beats++;
            @(posedge clk);
        end
        @(negedge clk); f_valid = 1'b0;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (f_done === 1'b1) begin lat = c; got = 1'b1; break; end
        end
        n_checks++; if (!got || lat != 2) begin n_fail++; $display("FAIL full_latency got=%0d seen=%b exp=2", lat, got); end
        for (int k = 0; k < 128; k++) begin
            n_checks++;
            if (f_out[k*8 +: 8] !== 8'(requant(mdl[k] + longint'(bv[k]), 7))) begin
                n_fail++;
                $display("FAIL full_lane%0d got=%0d exp=%0d", k, f_out[k*8 +: 8], requant(mdl[k] + longint'(bv[k]), 7));
            end
        end
        repeat (20) @(negedge clk);
        n_checks++; if (f_done_cnt - d0 != 1) begin n_fail++; $display("FAIL full_one_done got=%0d exp=1", f_done_cnt - d0); end
        f_run = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (f_busy !== 1'b0) begin n_fail++; $display("FAIL full_idle_busy got=%b exp=0", f_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random_small();
        test_full(255, 128);
        test_full(31, 16);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
